multicycle_controller: RTL and testbench

Control FSM that sequences the shared RV32I multi-cycle datapath: instruction register, register file, one ALU, immediate extender, and a unified instruction/data memory with a ready handshake.
- Decodes opcode, funct3 and funct7[5] from the instruction register.
- Drives the immediate-extender select and all mux selects and write enables, state by state.
- Supported instructions: R-type, I-ALU, lw, sw, beq/bne, jal, jalr, lui.
- Sits beside the datapath top; replaces the single-cycle combinational decoder.

---
 rtl/riscv_ctrl_pkg.sv | 59 +++++
 rtl/alu_decoder.sv | 34 +++
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I multi-cycle datapath: FSM states,
// opcodes and the mux/ALU select codes also used by the extender and ALU.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2, S_LUIWB
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            OP_LUI:  return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU request plus funct fields to an ALUControl code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        op5,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // bit 30 is an immediate bit for I-type, so only R-type may subtract
                    3'b000: alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b011: alu_control = ALU_SLT;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: alu_control = ALU_SRL;
                    3'b110: alu_control = ALU_OR;
                    3'b111: alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/writeback on
// the shared datapath and watches memory wait states for a stall timeout.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter state_t      RESET_STATE = S_FETCH,
    parameter int unsigned WAIT_LIMIT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemReq,
    output logic        illegal_instr,
    output logic        mem_timeout
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    state_t         state, state_nxt;
    alu_op_t        alu_op;
    logic           irw, pcw, rw, mw, mq, ill, waiting;
    logic [CW-1:0]  wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        irw       = 1'b0;
        pcw       = 1'b0;
        rw        = 1'b0;
        mw        = 1'b0;
        mq        = 1'b0;
        ill       = 1'b0;
        waiting   = 1'b0;
        case (state)
            S_FETCH: begin
                mq        = 1'b1;
                waiting   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                irw       = mem_ready;
                pcw       = mem_ready;
                if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_BR:        state_nxt = S_BRANCH;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_JALR:      state_nxt = S_JALR;
                    OP_LUI:       state_nxt = S_LUIWB;
                    default: begin
                        // PC was already bumped in FETCH, so just move on
                        ill       = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mq      = 1'b1;
                waiting = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rw        = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                mq      = 1'b1;
                waiting = 1'b1;
                AdrSrc  = 1'b1;
                mw      = mem_ready;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA   = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                rw        = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                pcw       = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pcw       = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = S_JALR2;
            end
            S_JALR2: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pcw       = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_LUIWB: begin
                ResultSrc = RES_IMM;
                rw        = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Saturates at WAIT_LIMIT so the timeout fires once per stall
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (!waiting || mem_ready || (state_nxt != state))
            wait_cnt <= '0;
        else if (wait_cnt != CW'(WAIT_LIMIT))
            wait_cnt <= wait_cnt + 1'b1;
    end

    alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

    assign ImmSrc        = imm_src(op);
    assign IRWrite       = irw & ~reset;
    assign PCWrite       = pcw & ~reset;
    assign RegWrite      = rw  & ~reset;
    assign MemWrite      = mw  & ~reset;
    assign MemReq        = mq  & ~reset;
    assign illegal_instr = ill & ~reset;
    assign mem_timeout   = ~reset && (WAIT_LIMIT != 0) && waiting && !mem_ready
                           && (wait_cnt == CW'(WAIT_LIMIT - 1));

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors
// go through a scoreboard queue and are compared against the DUT outputs.
module tb_multicycle_controller;

    typedef enum int {
        T_FETCH, T_DECODE, T_DECILL, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
        T_EXECR, T_EXECI, T_ALUWB, T_BRANCH, T_JAL, T_JALR, T_JALR2, T_LUIWB
    } step_t;

    logic        clk = 1'b0;
    logic        reset, funct7b5, zero, mem_ready;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [2:0]  ImmSrc, ALUControl;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, MemReq;
    logic        illegal_instr, mem_timeout;
    logic [19:0] obs;

    logic [2:0]  exp_imm, exp_alu;
    logic        exp_taken, rst_exp;
    int          errors = 0;
    int          checks = 0;
    logic [19:0] sb_q[$];

    multicycle_controller #(.WAIT_LIMIT(255)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemReq(MemReq), .illegal_instr(illegal_instr),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, AdrSrc,
                  IRWrite, PCWrite, RegWrite, MemWrite, MemReq, illegal_instr, mem_timeout};

    // Expected control word for one cycle, written straight from the state table
    function automatic logic [19:0] expv(input step_t s, input logic mr, input logic to);
        logic [2:0] al = 3'b000;
        logic [1:0] sa = 2'b00, sbs = 2'b00, rs = 2'b00;
        logic ad = 0, irw = 0, pcw = 0, rw = 0, mw = 0, mq = 0, il = 0, t = to;
        case (s)
            T_FETCH:    begin mq = 1; sbs = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            T_DECODE:   begin sa = 2'b01; sbs = 2'b01; end
            T_DECILL:   begin sa = 2'b01; sbs = 2'b01; il = 1; end
            T_MEMADR:   begin sa = 2'b10; sbs = 2'b01; end
            T_MEMREAD:  begin mq = 1; ad = 1; end
            T_MEMWB:    begin rs = 2'b01; rw = 1; end
            T_MEMWRITE: begin mq = 1; ad = 1; mw = mr; end
            T_EXECR:    begin sa = 2'b10; al = exp_alu; end
            T_EXECI:    begin sa = 2'b10; sbs = 2'b01; al = exp_alu; end
            T_ALUWB:    rw = 1;
            T_BRANCH:   begin sa = 2'b10; al = 3'b001; pcw = exp_taken; end
            T_JAL:      begin sa = 2'b01; sbs = 2'b10; pcw = 1; end
            T_JALR:     begin sa = 2'b10; sbs = 2'b01; end
            T_JALR2:    begin sa = 2'b01; sbs = 2'b10; pcw = 1; end
            T_LUIWB:    begin rs = 2'b11; rw = 1; end
            default: ;
        endcase
        if (rst_exp) begin
            irw = 0; pcw = 0; rw = 0; mw = 0; mq = 0; il = 0; t = 0;
        end
        return {exp_imm, sa, sbs, al, rs, ad, irw, pcw, rw, mw, mq, il, t};
    endfunction

    task automatic set_instr(input logic [31:0] ins, input logic [2:0] imm, input logic [2:0] alu);
        op       = ins[6:0];
        funct3   = ins[14:12];
        funct7b5 = ins[30];
        exp_imm  = imm;
        exp_alu  = alu;
    endtask

    // One clock cycle: drive, push expectation, compare at the falling edge
    task automatic cyc(input step_t s, input logic mr, input string tag, input logic to = 1'b0);
        logic [19:0] e;
        mem_ready = mr;
        sb_q.push_back(expv(s, mr, to));
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; zero = 0; mem_ready = 0; rst_exp = 1; exp_taken = 0;
        set_instr(32'h002081B3, 3'b000, 3'b000);
        @(posedge clk); #1;
        cyc(T_FETCH, 1, "reset_fetch");
        reset = 0; rst_exp = 0;

        cyc(T_FETCH, 1, "add_fetch"); cyc(T_DECODE, 1, "add_decode");
        cyc(T_EXECR, 1, "add_exec");  cyc(T_ALUWB, 1, "add_wb");

        set_instr(32'h40208133, 3'b000, 3'b001);
        cyc(T_FETCH, 1, "sub_fetch"); cyc(T_DECODE, 1, "sub_decode");
        cyc(T_EXECR, 1, "sub_exec");  cyc(T_ALUWB, 1, "sub_wb");

        set_instr(32'hC0000093, 3'b000, 3'b000);
        cyc(T_FETCH, 1, "addi_fetch"); cyc(T_DECODE, 1, "addi_decode");
        cyc(T_EXECI, 1, "addi_exec");  cyc(T_ALUWB, 1, "addi_wb");

        set_instr(32'h0040C093, 3'b000, 3'b100);
        cyc(T_FETCH, 1, "xori_fetch"); cyc(T_DECODE, 1, "xori_decode");
        cyc(T_EXECI, 1, "xori_exec");  cyc(T_ALUWB, 1, "xori_wb");

        set_instr(32'h00802283, 3'b000, 3'b000);
        cyc(T_FETCH, 1, "lw_fetch"); cyc(T_DECODE, 1, "lw_decode"); cyc(T_MEMADR, 1, "lw_memadr");
        for (int i = 0; i < 3; i++) cyc(T_MEMREAD, 0, "lw_memread_wait");
        cyc(T_MEMREAD, 1, "lw_memread"); cyc(T_MEMWB, 1, "lw_wb");

        set_instr(32'h00512423, 3'b001, 3'b000);
        cyc(T_FETCH, 0, "sw_fetch_wait"); cyc(T_FETCH, 1, "sw_fetch");
        cyc(T_DECODE, 1, "sw_decode"); cyc(T_MEMADR, 1, "sw_memadr");
        cyc(T_MEMWRITE, 0, "sw_memwrite_wait"); cyc(T_MEMWRITE, 0, "sw_memwrite_wait");
        cyc(T_MEMWRITE, 1, "sw_memwrite");

        set_instr(32'h00208463, 3'b010, 3'b000);
        zero = 1; exp_taken = 1;
        cyc(T_FETCH, 1, "beq_t_fetch"); cyc(T_DECODE, 1, "beq_t_decode"); cyc(T_BRANCH, 1, "beq_taken");
        zero = 0; exp_taken = 0;
        cyc(T_FETCH, 1, "beq_n_fetch"); cyc(T_DECODE, 1, "beq_n_decode"); cyc(T_BRANCH, 1, "beq_not_taken");

        set_instr(32'h00209463, 3'b010, 3'b000);
        zero = 0; exp_taken = 1;
        cyc(T_FETCH, 1, "bne_t_fetch"); cyc(T_DECODE, 1, "bne_t_decode"); cyc(T_BRANCH, 1, "bne_taken");
        zero = 1; exp_taken = 0;
        cyc(T_FETCH, 1, "bne_n_fetch"); cyc(T_DECODE, 1, "bne_n_decode"); cyc(T_BRANCH, 1, "bne_not_taken");

        set_instr(32'h0020C463, 3'b010, 3'b000);
        zero = 1; exp_taken = 0;
        cyc(T_FETCH, 1, "blt_fetch"); cyc(T_DECODE, 1, "blt_decode"); cyc(T_BRANCH, 1, "blt_never_taken");
        zero = 0;

        set_instr(32'h008000EF, 3'b011, 3'b000);
        cyc(T_FETCH, 1, "jal_fetch"); cyc(T_DECODE, 1, "jal_decode");
        cyc(T_JAL, 1, "jal_exec");     cyc(T_ALUWB, 1, "jal_wb");

        set_instr(32'h000080E7, 3'b000, 3'b000);
        cyc(T_FETCH, 1, "jalr_fetch"); cyc(T_DECODE, 1, "jalr_decode");
        cyc(T_JALR, 1, "jalr_exec");   cyc(T_JALR2, 1, "jalr_exec2"); cyc(T_ALUWB, 1, "jalr_wb");

        set_instr(32'h123452B7, 3'b100, 3'b000);
        cyc(T_FETCH, 1, "lui_fetch"); cyc(T_DECODE, 1, "lui_decode"); cyc(T_LUIWB, 1, "lui_wb");

        set_instr(32'h0000007F, 3'b000, 3'b000);
        cyc(T_FETCH, 1, "ill_fetch"); cyc(T_DECILL, 1, "ill_decode");

        // Long fetch stall: timeout fires on the 255th low cycle only
        set_instr(32'h123452B7, 3'b100, 3'b000);
        for (int i = 0; i < 254; i++) cyc(T_FETCH, 0, "stall_wait");
        cyc(T_FETCH, 0, "stall_timeout", 1'b1);
        cyc(T_FETCH, 0, "stall_saturated"); cyc(T_FETCH, 0, "stall_saturated");
        cyc(T_FETCH, 1, "stall_fetch"); cyc(T_DECODE, 1, "stall_decode"); cyc(T_LUIWB, 1, "stall_wb");

        // Reset while a load is waiting on memory
        set_instr(32'h00802283, 3'b000, 3'b000);
        cyc(T_FETCH, 1, "rst_lw_fetch"); cyc(T_DECODE, 1, "rst_lw_decode");
        cyc(T_MEMADR, 1, "rst_lw_memadr"); cyc(T_MEMREAD, 0, "rst_lw_memread");
        reset = 1; rst_exp = 1;
        cyc(T_MEMREAD, 1, "rst_in_memread");
        reset = 0; rst_exp = 0;
        cyc(T_FETCH, 1, "post_rst_fetch"); cyc(T_DECODE, 1, "post_rst_decode");
        cyc(T_MEMADR, 1, "post_rst_memadr"); cyc(T_MEMREAD, 1, "post_rst_memread");
        cyc(T_MEMWB, 1, "post_rst_wb");
        cyc(T_FETCH, 1, "final_fetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
